// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the bus side.
// Each entry holds one character plus its parity and stop-bit error flags.
// The read side is first-word-fall-through. The fill level is held in its own
// count register, and all status flags are registered from the next count.
//
// Handshake: the head entry is transferred on every rising clock edge where
// o_rd_valid and i_rd_ready are both high. o_rd_valid never depends
// combinationally on i_rd_ready. While o_rd_valid is low, the o_rd_* payload
// is driven to zero.
module uart_rx_fifo #(
    parameter int DataLength      = 8,
    parameter int Depth           = 16,
    parameter int AlmostFullLevel = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [DataLength-1:0]      i_wr_data,
    input  logic                       i_wr_parity_err,
    input  logic                       i_wr_stop_err,
    input  logic                       i_flush,
    input  logic                       i_clr_overflow,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [DataLength-1:0]      o_rd_data,
    output logic                       o_rd_parity_err,
    output logic                       o_rd_stop_err,
    output logic [$clog2(Depth):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overflow
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam int WW = DataLength + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [CW-1:0] AFULL_C = CW'(AlmostFullLevel);

    // Entry layout: {stop_err, parity_err, data}
    logic [WW-1:0] mem [Depth];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          afull_q;
    logic          overflow_q;
    logic          pop;
    logic          push;
    logic          drop;
    logic [WW-1:0] head;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle. A flush discards any push or pop in its cycle.
    always_comb begin
        pop  = !empty_q && i_rd_ready && !i_flush;
        push = i_wr_en && (!full_q || (!empty_q && i_rd_ready)) && !i_flush;
        drop = i_wr_en && full_q && !i_rd_ready && !i_flush;
    end

    // Next fill level; flush wins, and a simultaneous push+pop leaves it unchanged.
    always_comb begin
        count_nxt = count_q;
        if (i_flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointers, count and status flags; the flags are derived from count_nxt so they always match o_count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
            afull_q <= (count_nxt >= AFULL_C);
        end
    end

    // Sticky overflow: a dropped push outranks a clear in the same cycle; flush leaves it alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {i_wr_stop_err, i_wr_parity_err, i_wr_data};
        end
    end

    // Head presentation, zeroed whenever nothing is valid.
    always_comb begin
        head            = mem[rd_ptr_q];
        o_rd_valid      = !empty_q;
        o_rd_data       = empty_q ? '0 : head[DataLength-1:0];
        o_rd_parity_err = empty_q ? 1'b0 : head[DataLength];
        o_rd_stop_err   = empty_q ? 1'b0 : head[DataLength+1];
        o_count         = count_q;
        o_empty         = empty_q;
        o_full          = full_q;
        o_almost_full   = afull_q;
        o_overflow      = overflow_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo.
// Inputs change 1 ns after the rising edge, and outputs are checked there too.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_pe;
    logic       wr_se;
    logic       flush;
    logic       clr_ov;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_pe;
    logic       rd_se;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       afull;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DataLength(8), .Depth(16), .AlmostFullLevel(12)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_data      (wr_data),
        .i_wr_parity_err(wr_pe),
        .i_wr_stop_err  (wr_se),
        .i_flush        (flush),
        .i_clr_overflow (clr_ov),
        .o_rd_valid     (rd_valid),
        .i_rd_ready     (rd_ready),
        .o_rd_data      (rd_data),
        .o_rd_parity_err(rd_pe),
        .o_rd_stop_err  (rd_se),
        .o_count        (count),
        .o_empty        (empty),
        .o_full         (full),
        .o_almost_full  (afull),
        .o_overflow     (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_data = 0; wr_pe = 0; wr_se = 0;
        flush = 0; clr_ov = 0; rd_ready = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic se);
        wr_en = 1; wr_data = d; wr_pe = pe; wr_se = se;
        cycle();
        wr_en = 0; wr_pe = 0; wr_se = 0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, d);
        rd_ready = 1;
        cycle();
        rd_ready = 0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_valid"}, rd_valid, 0);
        check({tag, "_data"}, rd_data, 0);
        check({tag, "_pe"}, rd_pe, 0);
        check({tag, "_se"}, rd_se, 0);
    endtask

    initial begin
        logic mpop;
        logic mpush;
        idle();
        rst = 1;
        #12;
        // Reset state
        check_empty("rst");
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 0;
        cycle();

        // 1. Basic order
        push(8'h41, 0, 0);
        check("t1_latency_valid", rd_valid, 1);
        push(8'h42, 0, 0);
        push(8'h43, 0, 0);
        check("t1_count", count, 3);
        check("t1_head", rd_data, 8'h41);
        pop_check("t1_p0", 8'h41);
        pop_check("t1_p1", 8'h42);
        pop_check("t1_p2", 8'h43);
        check_empty("t1_end");

        // 2. Fill to full, almost-full threshold, overflow
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 0, 0);
            check("t2_count", count, i + 1);
            check("t2_afull", afull, (i + 1 >= 12) ? 1 : 0);
        end
        check("t2_full", full, 1);
        check("t2_ovf_before", overflow, 0);
        push(8'hAA, 0, 0);
        check("t2_ovf", overflow, 1);
        check("t2_count_after_drop", count, 16);
        for (int i = 0; i < 16; i++) pop_check("t2_drain", 8'(i));
        check_empty("t2_end");
        check("t2_ovf_sticky", overflow, 1);
        clr_ov = 1; cycle(); clr_ov = 0;
        check("t2_ovf_clr", overflow, 0);

        // 3. Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 0, 0);
        check("t3_full", full, 1);
        wr_en = 1; wr_data = 8'h55; rd_ready = 1;
        cycle();
        idle();
        check("t3_count", count, 16);
        check("t3_full_kept", full, 1);
        check("t3_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) pop_check("t3_drain", 8'h20 + 8'(i));
        pop_check("t3_last", 8'h55);
        check_empty("t3_end");

        // 4. Error flags travel with their word
        push(8'h7E, 1, 0);
        push(8'h11, 0, 1);
        check("t4_data", rd_data, 8'h7E);
        check("t4_pe", rd_pe, 1);
        check("t4_se", rd_se, 0);
        pop_check("t4_p0", 8'h7E);
        check("t4_pe2", rd_pe, 0);
        check("t4_se2", rd_se, 1);
        pop_check("t4_p1", 8'h11);
        check_empty("t4_end");

        // 5. Overflow set beats clear; flush behaviour
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), 0, 0);
        wr_en = 1; wr_data = 8'hEE; clr_ov = 1;
        cycle();
        idle();
        check("t5_set_beats_clr", overflow, 1);
        wr_en = 1; wr_data = 8'hEF; flush = 1;
        cycle();
        idle();
        check_empty("t5_flush_full");
        check("t5_full_flag", full, 0);
        check("t5_afull_flag", afull, 0);
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 0, 0);
        check("t5_count5", count, 5);
        wr_en = 1; wr_data = 8'hBB; flush = 1; rd_ready = 1;
        cycle();
        idle();
        check_empty("t5_flush5");
        check("t5_ovf_kept", overflow, 1);
        clr_ov = 1; cycle(); clr_ov = 0;
        check("t5_ovf_clr", overflow, 0);
        push(8'h77, 0, 0);
        pop_check("t5_after_flush", 8'h77);

        // 6. Pointer wrap with random ready, checked against a queue model
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            wr_en = 1;
            wr_data = 8'h80 + 8'(k);
            rd_ready = ($urandom_range(0, 3) != 0);
            mpop = (exp_q.size() > 0) && rd_ready;
            check("t6_valid", rd_valid, (exp_q.size() > 0) ? 1 : 0);
            if (mpop) check("t6_data", rd_data, exp_q.pop_front());
            mpush = (exp_q.size() < 16) || mpop;
            if (mpush) exp_q.push_back(wr_data);
            cycle();
            check("t6_count", count, exp_q.size());
        end
        idle();
        push(8'hC0, 0, 0);
        exp_q.push_back(8'hC0);
        check("t6_count_pre_rst", count, exp_q.size());
        // Asynchronous reset in mid-cycle
        #2 rst = 1;
        #1;
        check("t6_rst_valid", rd_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_data", rd_data, 0);
        cycle();
        rst = 0;
        push(8'h99, 0, 0);
        check("t6_release_push_count", count, 1);
        check("t6_release_push_data", rd_data, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
